// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, default reset PC and PC increment,
// and the instruction-queue entry layout {pc, instr}.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'd0;
    localparam logic [31:0] PC_INC_DEF   = 32'd1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs for decode.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: caller must not push when full (unless popping); flush beats push.
//
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   push_i / push_dat_i   write an entry at the tail
//   pop_i                 remove the head entry (ignored when empty)
//   flush_i               empty the queue at this edge; wins over push and pop
//   head_dat_o            head entry, zero when empty
//   count_o               number of valid entries, 0..DEPTH
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  qentry_t       push_dat_i,
    output qentry_t       head_dat_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    qentry_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns fetch PC, requests imem, queues words for decode.
// Latency: zero-wait memory gives first id_valid 2 cycles after reset release, then 1/cycle.
// Backpressure: no new imem request while the queue is full; redirects flush and squash.
//
// Ports:
//   clock, reset_n                       clock, asynchronous active-low reset
//   redirect_valid, redirect_target      taken branch/jump from execute
//   imem_req, imem_addr                  request to instruction memory (held until ack)
//   imem_ack, imem_rdata                 memory completion and returned word
//   id_valid, id_instr, id_pc, id_ready  queue head handed to decode
//   next_pc                              current fetch PC for the architectural PC register
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_INC   = PC_INC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic [31:0] next_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   addr_q;
    logic          req_q;
    logic [31:0]   pc_d;
    logic [CW-1:0] q_count;
    logic [CW-1:0] cnt_d;
    logic          room_d;
    logic          xfer;
    logic          push;
    logic          pop;
    qentry_t       push_dat;
    qentry_t       head;

    assign xfer     = req_q && imem_ack;
    assign push     = (state_q == FETCH) && xfer && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign push_dat = '{pc: fetch_pc_q, instr: imem_rdata};

    // Next fetch PC: a redirect always wins, otherwise advance on an accepted word.
    always_comb begin
        pc_d = fetch_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (push) begin
            pc_d = fetch_pc_q + PC_INC;
        end
    end

    // Queue occupancy after this edge; decides whether a request may be raised
    // next cycle so that imem_req can be a plain register.
    always_comb begin
        cnt_d = q_count + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            cnt_d = '0;
        end
    end

    assign room_d = (cnt_d < CW'(DEPTH));

    // addr_q tracks fetch_pc_q except in DISCARD, where it must keep presenting
    // the squashed address until memory acknowledges it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    fetch_pc_q <= pc_d;
                    addr_q     <= pc_d;
                    req_q      <= room_d;
                end
                FETCH: begin
                    if (redirect_valid && req_q && !imem_ack) begin
                        // Request in flight: keep req/addr stable and drop its data later.
                        state_q    <= DISCARD;
                        fetch_pc_q <= redirect_target;
                        req_q      <= 1'b1;
                    end else begin
                        fetch_pc_q <= pc_d;
                        addr_q     <= pc_d;
                        req_q      <= room_d;
                    end
                end
                DISCARD: begin
                    fetch_pc_q <= pc_d;
                    if (imem_ack) begin
                        state_q <= FETCH;
                        addr_q  <= pc_d;
                        req_q   <= room_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    fetch_pc_q <= RESET_PC;
                    addr_q     <= RESET_PC;
                    req_q      <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .push_dat_i (push_dat),
        .head_dat_o (head),
        .count_o    (q_count)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign next_pc   = fetch_pc_q;
    assign id_valid  = (q_count != '0);
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with a transaction-level reference model.
// The model keeps the decode queue as a plain SV queue of expected {pc, instr}
// entries; a negedge monitor compares DUT outputs and pops on each handshake.
module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'd0;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [31:0] next_pc;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .PC_INC   (32'd1),
        .DEPTH    (DEPTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_ready        (id_ready),
        .next_pc         (next_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_disc_addr;
    bit          m_idle;
    bit          m_discard;
    bit          m_req_cyc;

    // Model state advances on each clock edge from the bench's own inputs.
    initial begin
        m_pc = RST_PC; m_disc_addr = RST_PC; m_idle = 1; m_discard = 0; m_req_cyc = 0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_pc = RST_PC; m_disc_addr = RST_PC; m_idle = 1; m_discard = 0; m_req_cyc = 0;
                exp_q.delete();
            end else begin
                if (m_idle) begin
                    m_idle = 0;
                    if (redirect_valid) m_pc = redirect_target;
                end else if (m_discard) begin
                    if (redirect_valid) m_pc = redirect_target;
                    if (imem_ack) m_discard = 0;
                end else if (redirect_valid) begin
                    if (m_req_cyc && !imem_ack) begin
                        m_discard   = 1;
                        m_disc_addr = m_pc;
                    end
                    m_pc = redirect_target;
                end else if (m_req_cyc && imem_ack) begin
                    exp_q.push_back('{m_pc, m_pc + 32'h100});
                    m_pc = m_pc + 32'd1;
                end
                if (redirect_valid) exp_q.delete();
            end
        end
    end

    // Monitor: compares every cycle away from the clock edge; pops on handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                m_req_cyc = m_discard || (!m_idle && (exp_q.size() < DEPTH));
                chk("imem_req", imem_req, m_req_cyc);
                chk("imem_addr", imem_addr, m_discard ? m_disc_addr : m_pc);
                chk("next_pc", next_pc, m_pc);
                chk("id_valid", id_valid, exp_q.size() != 0);
                if (exp_q.size() != 0 && id_ready) begin
                    chk("id_pc", id_pc, exp_q[0].pc);
                    chk("id_instr", id_instr, exp_q[0].instr);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int          cfg_lat;     // <0 : random 0..3 wait cycles
    int          cfg_rdy;     // 0 hold low, 1 hold high, 2 random
    int          redir_mode;  // 0 none, 1 random, 2 on 2nd wait, 3 on ack of pc5 + pop, 4 now
    logic [31:0] redir_tgt;
    bit          redir_fired;
    bit          mem_busy;
    int          mem_wait;

    task automatic drive_mem();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_wait = (cfg_lat < 0) ? int'($urandom_range(0, 3)) : cfg_lat;
            end
            if (mem_wait == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr + 32'h100;
                mem_busy   = 0;
            end else begin
                mem_wait--;
            end
        end
    endtask

    task automatic fire();
        redirect_valid  = 1'b1;
        redirect_target = redir_tgt;
        redir_mode      = 0;
        redir_fired     = 1;
    endtask

    task automatic apply();
        logic [31:0] t;
        redirect_valid = 1'b0;
        drive_mem();
        case (cfg_rdy)
            0:       id_ready = 1'b0;
            1:       id_ready = 1'b1;
            default: id_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (redir_mode)
            1: if ($urandom_range(0, 15) == 0) begin
                   t = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                                    : 32'($urandom_range(0, 255)));
                   redirect_valid  = 1'b1;
                   redirect_target = t;
               end
            2: if (mem_busy && mem_wait == 0 && !imem_ack) fire();
            3: if (imem_ack && imem_addr == 32'd5 && id_valid && id_ready) fire();
            4: fire();
            default: ;
        endcase
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            apply();
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_next_pc", next_pc, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        id_ready       = 1'b0;
        mem_busy       = 0;
        mem_wait       = 0;
        redir_mode     = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        apply();
    endtask

    initial begin
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
        cfg_lat = 0; cfg_rdy = 1; redir_mode = 0; redir_tgt = 32'd0;
        redir_fired = 0; mem_busy = 0; mem_wait = 0;
        repeat (2) @(posedge clock);

        // Zero-wait memory, decode always ready: first word in cycle 2.
        do_reset();
        step(1);
        chk("cyc1_id_valid", id_valid, 1'b0);
        step(1);
        chk("cyc2_id_valid", id_valid, 1'b1);
        chk("cyc2_id_pc", id_pc, 32'd0);
        chk("cyc2_id_instr", id_instr, 32'h100);
        step(10);

        // Decode stalls: queue fills and the request drops, then drains.
        do_reset();
        cfg_rdy = 0;
        step(5);
        cfg_rdy = 1;
        step(10);

        // Three-cycle memory, redirect on the second wait cycle.
        cfg_lat = 2; redir_tgt = 32'h40; redir_fired = 0; redir_mode = 2;
        for (int i = 0; i < 30 && !redir_fired; i++) step(1);
        chk("wait_redirect_fired", redir_fired, 1'b1);
        step(12);

        // Redirect coinciding with the ack of pc 5 and a pop.
        cfg_lat = 0;
        do_reset();
        redir_tgt = 32'h80; redir_fired = 0; redir_mode = 3;
        for (int i = 0; i < 30 && !redir_fired; i++) step(1);
        chk("ack_redirect_fired", redir_fired, 1'b1);
        step(1);
        chk("post_redirect_id_valid", id_valid, 1'b0);
        chk("post_redirect_next_pc", next_pc, 32'h80);
        step(8);

        // Wrap of the fetch PC through 0xFFFFFFFF.
        redir_tgt = 32'hFFFF_FFFF; redir_mode = 4;
        step(10);

        // Long random run: random latency, ready and redirects.
        cfg_lat = -1; cfg_rdy = 2; redir_mode = 1;
        step(3000);

        // Reset while a request is outstanding with data queued.
        redir_mode = 0; cfg_lat = 3; cfg_rdy = 0;
        redir_fired = 0;
        for (int i = 0; i < 40 && !(imem_req && id_valid); i++) step(1);
        chk("busy_before_reset", {imem_req, id_valid}, 2'b11);
        do_reset();
        cfg_lat = 0; cfg_rdy = 1;
        step(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
